alu_sched: RTL
==============

// Module: alu_sched
// PURPOSE
//  Shares one 4-bit combinational alu instance between NREQ requesters with valid/ready handshakes.
//  - Arbitrates requesters, latches the granted operands and opcode, and drives the shared alu.
//  - Registers the alu result and returns it with the requester id on a single response channel.
//  - Sits between issuing engines (sequencers, testers) and the alu datapath.
// PARAMETERS
//  NREQ  2  number of requesters, legal range 1..4
//  RR    1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  req_valid   in   NREQ      per-requester operation valid
//  req_ready   out  NREQ      per-requester accept; one-hot or zero
//  req_a       in   NREQ*4    operand A, requester i at [4i+3:4i]
//  req_b       in   NREQ*4    operand B, same packing as req_a
//  req_op      in   NREQ*3    opcode, requester i at [3i+2:3i]
//  rsp_valid   out  1         response valid
//  rsp_ready   in   1         response accept
//  rsp_id      out  2         index of the requester that issued the op
//  rsp_result  out  4         alu result
//  rsp_carry   out  1         alu carry, passed through unchanged
//  rsp_err     out  1         illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 unused.
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: if any req_valid is high, the arbiter picks grant g.
//    - req_ready[g] is high combinationally in this cycle; it is 0 in all other states.
//    - Handshake completes when req_valid[g] && req_ready[g]; A, B, op and id are latched; go to EXEC.
//  - EXEC: latched operands drive the alu; result and carry are registered into rsp_* regs; go to RESP.
//  - RESP: rsp_valid=1 and rsp_* stay stable until rsp_ready; on rsp_valid && rsp_ready, go to IDLE.
//  - Latency: accept at cycle T -> rsp_valid at T+2. Peak throughput is 1 op per 3 cycles.
//  - A new request can be accepted in the cycle after the response handshake, not in the same cycle.
//  - RR pointer: reset value 0; after each accept, pointer = (g+1) mod NREQ.
//    - Search starts at the pointer and wraps through NREQ-1 to 0.
//  - RR=0: the pointer is ignored and the lowest valid index wins.
//  - Simultaneous valids: exactly one grant; losers hold valid, and their inputs must stay stable.
//  - Width: 4-bit wrap; the alu defines carry; the scheduler does no arithmetic itself.
//  - Reset, asynchronous and valid in any state:
//    - state = IDLE, pointer = 0.
//    - rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err all = 0.
//    - An op in flight is dropped and no response is produced.
//  - While rst_n is low, req_ready = 0.
// CONFIGURATION
//  Macro ALU_ILLEGAL_OP_EN:
//   - Defined: opcode 111 does not drive the alu result.
//     - The op is accepted normally and the response carries result=0, carry=0, rsp_err=1.
//     - Timing is unchanged (T+2).
//   - Undefined: 111 is forwarded to the alu unchanged; rsp_err is tied to 0.
// STRUCTURE
//  - alu_pkg holds:
//    - opcode localparams OP_ADD..OP_SHR, OP_ILL = 3'b111;
//    - data width DW = 4;
//    - FSM encodings S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2.
//  - Sub-module rr_arbiter: NREQ-wide, combinational one-hot grant from valid and pointer.
//    - Its RR parameter selects fixed priority.
//    - The pointer register lives in alu_sched.
//  - Existing alu is instantiated once, unmodified.
// TESTING
//  1. req0: A=4, B=3, op=000 -> rsp_valid at T+2, rsp_id=0, result=7, carry=0.
//  2. req1: A=15, B=1, op=000 -> result=0, carry=1, rsp_id=1.
//  3. req0 and req1 held valid together from reset, RR=1, 4 ops.
//     -> rsp_id order 0,1,0,1. With RR=0 -> 0,0,0,0.
//  4. rsp_ready=0 for 5 cycles during RESP -> rsp_valid held, result/id stable, req_ready=0.
//     -> Accept occurs in the cycle after rsp_ready rises.
//  5. rst_n pulsed low during EXEC -> all rsp_* = 0 immediately, no response.
//     -> Pointer = 0, and the next contention grants req0.
//  6. op=111, A=5, B=3:
//     -> with ALU_ILLEGAL_OP_EN: rsp_err=1, result=0, carry=0.
//     -> without it: rsp_err=0 and result equals the alu output for 111.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu scheduler slice.
//   DW        datapath width of the shared alu
//   OP_*      alu opcodes (OP_ILL is the reserved encoding)
//   state_e   scheduler FSM encoding
package alu_pkg;

  localparam int unsigned DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit alu shared by the scheduler.
//   a, b   operands
//   op     opcode (see alu_pkg)
//   y      result, wraps at DW bits
//   cout   ADD: carry out; SUB: borrow; SHL/SHR: bit shifted out; others 0
// Opcode 111 returns ~a with cout 0.
module alu
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          cout
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[DW-1:0];
        cout = wide[DW];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[DW-1:0];
        cout = wide[DW];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y    = {a[DW-2:0], 1'b0};
        cout = a[DW-1];
      end
      OP_SHR: begin
        y    = {1'b0, a[DW-1:1]};
        cout = a[0];
      end
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational arbiter producing a one-hot grant.
//   valid    per-requester request
//   ptr      round-robin start index (ignored when RR = 0)
//   gnt      one-hot grant, zero when no valid
//   gnt_idx  binary index of the granted requester
// RR = 1: search starts at ptr and wraps; RR = 0: lowest valid index wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter bit          RR   = 1'b1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx
);

  localparam logic [NREQ-1:0] One = NREQ'(1);

  logic [1:0]        start;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [2:0]        sum;
  logic              found;

  // Rotating a doubled copy puts the start index at bit 0, so a plain
  // lowest-index search gives the wrapped round-robin order.
  always_comb begin
    start   = RR ? ptr : 2'd0;
    dbl     = {valid, valid} >> start;
    rot     = dbl[NREQ-1:0];
    gnt     = '0;
    gnt_idx = '0;
    sum     = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, start} + 3'(i);
        if (sum >= 3'(NREQ)) begin
          sum = sum - 3'(NREQ);
        end
        gnt_idx = sum[1:0];
        gnt     = One << sum;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one alu between NREQ requesters over valid/ready handshakes.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op      packed per-requester operands and opcode
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/result/carry/err response payload
// FSM IDLE -> EXEC -> RESP: accept at T gives rsp_valid at T+2.
// Optional feature macro ALU_ILLEGAL_OP_EN: opcode 111 returns result 0,
// carry 0 and rsp_err 1 instead of the alu output.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter bit          RR   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_a,
  input  logic [NREQ*4-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [3:0]        rsp_result,
  output logic              rsp_carry,
  output logic              rsp_err
);

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [DW-1:0]   a_q, b_q;
  logic [2:0]      op_q;
  logic [1:0]      id_q;
  logic            rsp_valid_q, rsp_carry_q, rsp_err_q;
  logic [1:0]      rsp_id_q;
  logic [DW-1:0]   rsp_result_q;

  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_idx;
  logic [1:0]      ptr_d;
  logic            accept;
  logic [DW-1:0]   sel_a, sel_b;
  logic [2:0]      sel_op;
  logic [DW-1:0]   alu_y, res_d;
  logic            alu_c, carry_d, err_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .RR   (RR)
  ) u_arb (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // rst_n gating keeps ready low during reset even though state is IDLE.
  assign req_ready = (rst_n && (state_q == S_IDLE)) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_d     = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*4 +: 4];
        sel_b  = req_b[i*4 +: 4];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .y    (alu_y),
    .cout (alu_c)
  );

`ifdef ALU_ILLEGAL_OP_EN
  always_comb begin
    err_d   = (op_q == OP_ILL);
    res_d   = err_d ? '0 : alu_y;
    carry_d = err_d ? 1'b0 : alu_c;
  end
`else
  always_comb begin
    err_d   = 1'b0;
    res_d   = alu_y;
    carry_d = alu_c;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= 2'd0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result_q <= res_d;
          rsp_carry_q  <= carry_d;
          rsp_err_q    <= err_d;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;

endmodule
